// File: rtl/ysyx_23060061_delay_pkg.sv
// ysyx_23060061_delay_pkg: shared encodings for the delay injector
// Contents:
//   DLY_OFF / DLY_FIXED / DLY_RANDOM  cfg_mode encodings (value 3 is reserved and behaves as OFF)
//   ch_state_e                        per-channel FSM state encoding
package ysyx_23060061_delay_pkg;

    localparam logic [1:0] DLY_OFF    = 2'd0;
    localparam logic [1:0] DLY_FIXED  = 2'd1;
    localparam logic [1:0] DLY_RANDOM = 2'd2;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_OPEN = 2'd2
    } ch_state_e;

endpackage

// File: rtl/ysyx_23060061_lfsr_galois.sv
// ysyx_23060061_lfsr_galois: free-running right-shifting Galois LFSR
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset, loads SEED (an all-zero SEED loads 1)
//   q    current LFSR state, advances every non-reset cycle
module ysyx_23060061_lfsr_galois #(
    parameter int              W    = 16,
    parameter logic [W-1:0]    TAPS = 16'hB400,
    parameter logic [W-1:0]    SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] q
);

    // The all-zero state is a lock-up state for an XOR LFSR.
    localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        r_q <= rst ? SEED_NZ : (r_q >> 1) ^ (r_q[0] ? TAPS : '0);
    end

    assign q = r_q;

endmodule

// File: rtl/ysyx_23060061_delay_injector.sv
// ysyx_23060061_delay_injector: multi-channel valid/ready latency injector with fixed or LFSR-random delays
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   cfg_mode               0 OFF, 1 FIXED, 2 RANDOM, 3 reserved (OFF)
//   cfg_fixed              delay used in FIXED mode
//   cfg_min, cfg_mask      RANDOM delay = min(cfg_min + (r_i & cfg_mask), max), saturating
//   in_valid / in_ready    upstream handshake, one bit per channel
//   out_valid / out_ready  downstream handshake, one bit per channel
//   lfsr_q                 shared LFSR state for scoreboards
module ysyx_23060061_delay_injector
    import ysyx_23060061_delay_pkg::*;
#(
    parameter int                NCH    = 2,
    parameter int                DLY_W  = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [DLY_W-1:0]  cfg_fixed,
    input  logic [DLY_W-1:0]  cfg_min,
    input  logic [DLY_W-1:0]  cfg_mask,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [LFSR_W-1:0] lfsr_q
);

    ysyx_23060061_lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Each channel views the LFSR through a different rotation so that
        // simultaneous arrivals do not draw identical delays.
        localparam int SH = (5 * i) % LFSR_W;

        ch_state_e        r_state;
        ch_state_e        w_next;
        logic [DLY_W-1:0] r_cnt;
        logic [DLY_W-1:0] r_dly;
        logic [DLY_W-1:0] w_r;
        logic [DLY_W-1:0] w_d;
        logic [DLY_W:0]   w_sum;
        logic             w_gate;
        logic             w_xfer;

        for (genvar b = 0; b < DLY_W; b++) begin : g_r
            assign w_r[b] = lfsr_q[(b + SH) % LFSR_W];
        end

        // Delay for an arrival in this cycle; the sum has a carry bit so it saturates instead of wrapping.
        always_comb begin
            w_sum = {1'b0, cfg_min} + {1'b0, w_r & cfg_mask};
            w_d   = (cfg_mode == DLY_OFF)    ? '0 :
                    (cfg_mode == DLY_FIXED)  ? cfg_fixed :
                    (cfg_mode == DLY_RANDOM) ? (w_sum[DLY_W] ? '1 : w_sum[DLY_W-1:0]) : '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= CH_IDLE;
                r_cnt   <= '0;
                r_dly   <= '0;
            end else begin
                r_state <= w_next;
                if (r_state == CH_IDLE && w_next == CH_WAIT) begin
                    r_cnt <= DLY_W'(1);
                    r_dly <= w_d;
                end else if (r_state == CH_WAIT && r_cnt != r_dly) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // A stalled open channel parks in OPEN; a dropped valid always aborts back to IDLE.
        always_comb begin
            w_next = (!in_valid[i] || w_xfer) ? CH_IDLE :
                     w_gate                   ? CH_OPEN :
                     (r_state == CH_IDLE)     ? CH_WAIT : r_state;
        end

        // The final WAIT cycle is already open so the first beat appears exactly D cycles after arrival.
        always_comb begin
            w_gate = !rst && (((r_state == CH_IDLE) && in_valid[i] && (w_d == '0)) ||
                              ((r_state == CH_WAIT) && in_valid[i] && (r_cnt == r_dly)) ||
                              (r_state == CH_OPEN));
            w_xfer = w_gate && in_valid[i] && out_ready[i];
        end

        assign out_valid[i] = w_gate && in_valid[i];
        assign in_ready[i]  = w_gate && out_ready[i];
    end

endmodule

// File: tb/tb_ysyx_23060061_delay_injector.sv
// tb_ysyx_23060061_delay_injector: directed self-checking bench for the delay injector
module tb_ysyx_23060061_delay_injector;

    localparam logic [1:0] M_OFF = 2'd0;
    localparam logic [1:0] M_FIX = 2'd1;
    localparam logic [1:0] M_RND = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_fixed;
    logic [7:0]  cfg_min;
    logic [7:0]  cfg_mask;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [15:0] lfsr_q;
    logic [15:0] m_q;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          d;
    int          d0;
    int          d1;

    ysyx_23060061_delay_injector dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_fixed (cfg_fixed),
        .cfg_min   (cfg_min),
        .cfg_mask  (cfg_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lfsr_q    (lfsr_q)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 Galois form with mask 0xB400, seed 0xACE1.
    always @(posedge clk) m_q <= rst ? 16'hACE1 : (m_q >> 1) ^ (m_q[0] ? 16'hB400 : 16'h0000);

    function automatic int exp_d(input logic [15:0] q, input int ch, input logic [7:0] mn, input logic [7:0] mk);
        logic [31:0] w;
        int          s;
        w = {q, q} >> ((5 * ch) % 16);
        s = int'(mn) + int'(w[7:0] & mk);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Arrival is in the current cycle; {out_valid,in_ready} must stay 0 for d cycles, then show channel b open.
    task automatic run(input string tag, input logic [1:0] b, input int dl);
        for (int k = 0; k <= dl; k++) begin
            if (k > 0) begin
                nxt();
                mid();
            end
            chk(tag, {28'd0, out_valid, in_ready}, (k == dl) ? {28'd0, b, b} : 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_mode  = M_OFF;
        cfg_fixed = 8'd0;
        cfg_min   = 8'd0;
        cfg_mask  = 8'd0;
        in_valid  = 2'b11;
        out_ready = 2'b11;
        // Reset forces both handshake outputs low even with a combinational pass requested.
        nxt(); mid();
        chk("rst_outputs", {28'd0, out_valid, in_ready}, 32'd0);
        chk("rst_lfsr", lfsr_q, 32'hACE1);
        nxt(); rst = 1'b0; in_valid = 2'b00; mid();
        chk("lfsr_0", lfsr_q, 32'hACE1);
        nxt(); mid();
        chk("lfsr_1", lfsr_q, 32'hE270);
        nxt(); mid();
        chk("lfsr_2", lfsr_q, 32'h7138);

        // FIXED 3 on ch0, then a back-to-back transfer that re-pays the delay.
        nxt(); cfg_mode = M_FIX; cfg_fixed = 8'd3; out_ready = 2'b01; in_valid = 2'b01; mid();
        run("fixed3", 2'b01, 3);
        nxt(); mid();
        run("fixed3_b2b", 2'b01, 3);
        nxt(); in_valid = 2'b00; mid();
        chk("fixed3_idle", {28'd0, out_valid, in_ready}, 32'd0);

        // OFF: open in the arrival cycle, stall two cycles, then complete.
        nxt(); cfg_mode = M_OFF; out_ready = 2'b00; in_valid = 2'b01; mid();
        chk("off_c0", {28'd0, out_valid, in_ready}, 32'b0100);
        nxt(); mid();
        chk("off_c1", {28'd0, out_valid, in_ready}, 32'b0100);
        nxt(); out_ready = 2'b01; mid();
        chk("off_c2", {28'd0, out_valid, in_ready}, 32'b0101);
        nxt(); in_valid = 2'b00; mid();
        chk("off_done", {28'd0, out_valid, in_ready}, 32'd0);

        // Reserved mode behaves as OFF regardless of cfg_fixed.
        nxt(); cfg_mode = M_RSV; cfg_fixed = 8'd7; in_valid = 2'b10; out_ready = 2'b10; mid();
        chk("reserved", {28'd0, out_valid, in_ready}, 32'b1010);
        nxt(); in_valid = 2'b00; mid();

        // RANDOM with zero mask gives exactly cfg_min, on ch1.
        nxt(); cfg_mode = M_RND; cfg_min = 8'd4; cfg_mask = 8'h00; in_valid = 2'b10; mid();
        run("rnd_min4", 2'b10, 4);
        nxt(); in_valid = 2'b00; out_ready = 2'b01; mid();

        // Config changes during WAIT leave the latched delay of 3 in force.
        nxt(); cfg_mode = M_FIX; cfg_fixed = 8'd3; in_valid = 2'b01; mid();
        chk("cfg_hold_0", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); cfg_mode = M_OFF; cfg_fixed = 8'd0; mid();
        chk("cfg_hold_1", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); mid();
        chk("cfg_hold_2", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); mid();
        chk("cfg_hold_3", {28'd0, out_valid, in_ready}, 32'b0101);
        nxt(); in_valid = 2'b00; mid();

        // Abort: FIXED 5, valid drops after two WAIT cycles, re-arrival with delay 1.
        nxt(); cfg_mode = M_FIX; cfg_fixed = 8'd5; in_valid = 2'b01; mid();
        chk("abort_arr", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); mid();
        chk("abort_w1", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); mid();
        chk("abort_w2", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); in_valid = 2'b00; mid();
        chk("abort_drop", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); in_valid = 2'b01; cfg_fixed = 8'd1; mid();
        run("abort_new", 2'b01, 1);
        nxt(); in_valid = 2'b00; mid();

        // Reset during WAIT drops the transfer; the held valid is a fresh arrival afterwards.
        nxt(); cfg_fixed = 8'd2; in_valid = 2'b01; mid();
        chk("rstw_arr", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); rst = 1'b1; mid();
        chk("rstw_forced", {28'd0, out_valid, in_ready}, 32'd0);
        nxt(); rst = 1'b0; mid();
        chk("rstw_lfsr", lfsr_q, 32'hACE1);
        run("rstw_new", 2'b01, 2);
        nxt(); in_valid = 2'b00; mid();

        // RANDOM near the top of the range must saturate at 255, never wrap below 250.
        for (int n = 0; n < 4; n++) begin
            nxt(); cfg_mode = M_RND; cfg_min = 8'd250; cfg_mask = 8'hFF; in_valid = 2'b01; mid();
            d = exp_d(m_q, 0, cfg_min, cfg_mask);
            run("rnd_sat", 2'b01, d);
            nxt(); in_valid = 2'b00; mid();
        end

        // Simultaneous arrivals: each channel uses its own rotated random word and completes on its own.
        for (int r = 0; r < 2; r++) begin
            nxt(); cfg_min = 8'd0; cfg_mask = 8'hFF; in_valid = 2'b11; out_ready = 2'b11; mid();
            d0 = exp_d(m_q, 0, cfg_min, cfg_mask);
            d1 = exp_d(m_q, 1, cfg_min, cfg_mask);
            for (int k = 0; k <= ((d0 > d1) ? d0 : d1); k++) begin
                if (k > 0) begin
                    nxt();
                    in_valid = {k <= d1, k <= d0};
                    mid();
                end
                chk("dual", {28'd0, out_valid, in_ready}, {28'd0, k == d1, k == d0, k == d1, k == d0});
            end
            nxt(); in_valid = 2'b00; mid();
            chk("dual_lfsr", lfsr_q, m_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
